product_accumulator: RTL

Sequential accumulate stage that sits directly downstream of the 4x4 combinational multiplier. It consumes the 8-bit products over a valid/ready handshake and sums a fixed-size batch of them into a wide accumulator. It presents the batch total on a second valid/ready handshake. Together the two blocks form a multiply-accumulate (dot-product) path.

---
 rtl/product_acc_pkg.sv | 15 +
 rtl/product_accumulator_if.sv | 31 +++
 rtl/product_acc_add.sv | 30 +++
 rtl/product_accumulator.sv | 103 ++++++++++
 4 files changed

// File: rtl/product_acc_pkg.sv
// Shared types and constants for the product accumulator: FSM states,
// product width and default sizing.
package product_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int PROD_W        = 8;
  localparam int DEFAULT_ACC_W = 16;
  localparam int DEFAULT_BATCH = 4;

endpackage

// File: rtl/product_accumulator_if.sv
// Bus between the multiplier-side producer, the accumulator and the result
// consumer; the master modport is the environment, slave is the accumulator.
interface product_accumulator_if #(
  parameter int ACC_W = product_acc_pkg::DEFAULT_ACC_W,
  parameter int BATCH = product_acc_pkg::DEFAULT_BATCH
);
  import product_acc_pkg::*;

  // Valid/ready: a transfer happens on a rising edge where valid && ready are
  // both high; valid and its payload must stay stable until that edge.
  logic                         clear;
  logic                         in_valid;
  logic                         in_ready;
  logic [PROD_W-1:0]            in_product;
  logic                         out_valid;
  logic                         out_ready;
  logic [ACC_W-1:0]             acc_out;
  logic [$clog2(BATCH+1)-1:0]   count;
  logic                         ovf;

  modport master (
    output clear, in_valid, in_product, out_ready,
    input  in_ready, out_valid, acc_out, count, ovf
  );

  modport slave (
    input  clear, in_valid, in_product, out_ready,
    output in_ready, out_valid, acc_out, count, ovf
  );

endinterface

// File: rtl/product_acc_add.sv
// Combinational accumulate adder with sticky overflow. Define
// PRODUCT_ACC_SATURATE_EN to clamp at full scale instead of wrapping.
module product_acc_add
  import product_acc_pkg::*;
#(
  parameter int ACC_W = DEFAULT_ACC_W
) (
  input  logic [ACC_W-1:0]  acc_in,
  input  logic [PROD_W-1:0] product,
  input  logic              ovf_in,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf_out
);

  logic [ACC_W:0] wide;
  logic           carry;

  always_comb begin
    wide    = {1'b0, acc_in} + {{(ACC_W + 1 - PROD_W){1'b0}}, product};
    carry   = wide[ACC_W];
    ovf_out = ovf_in | carry;
`ifdef PRODUCT_ACC_SATURATE_EN
    // Once the batch has overflowed it stays pinned at full scale.
    sum = (ovf_in | carry) ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
    sum = wide[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/product_accumulator.sv
// Batch accumulator behind the 4x4 multiplier: sums BATCH products and hands
// the total downstream. Wrap vs. saturate is selected by PRODUCT_ACC_SATURATE_EN.
module product_accumulator
  import product_acc_pkg::*;
#(
  parameter int ACC_W = DEFAULT_ACC_W,
  parameter int BATCH = DEFAULT_BATCH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  product_accumulator_if.slave  bus,
  output state_e                dbg_state
);

  localparam int CNT_W = $clog2(BATCH + 1);
  localparam logic [CNT_W-1:0] BATCH_CNT = CNT_W'(BATCH);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic             in_xfer;
  logic             out_xfer;
  logic [ACC_W-1:0] add_base;
  logic             add_ovf_in;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;

  assign in_xfer    = bus.in_valid && (state_q != ST_DONE);
  assign out_xfer   = bus.out_ready && (state_q == ST_DONE);
  // The first product of a batch loads rather than adds.
  assign add_base   = (state_q == ST_IDLE) ? '0 : acc_q;
  assign add_ovf_in = (state_q == ST_IDLE) ? 1'b0 : ovf_q;

  product_acc_add #(.ACC_W(ACC_W)) u_add (
    .acc_in  (add_base),
    .product (bus.in_product),
    .ovf_in  (add_ovf_in),
    .sum     (add_sum),
    .ovf_out (add_ovf)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (bus.clear) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ACCUM: begin
          if (in_xfer) begin
            acc_d   = add_sum;
            ovf_d   = add_ovf;
            count_d = count_q + CNT_W'(1);
            state_d = (count_d == BATCH_CNT) ? ST_DONE : ST_ACCUM;
          end
        end
        ST_DONE: begin
          if (out_xfer) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q != ST_DONE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.acc_out   = acc_q;
  assign bus.count     = count_q;
  assign bus.ovf       = ovf_q;
  assign dbg_state     = state_q;

endmodule
